// File: rtl/sm_minmax_tracker_pkg.sv
// Shared definitions for the sign-magnitude min/max tracker: defaults,
// controller state encoding, and notable sign-magnitude sample values.
package sm_pkg;

  localparam int SM_DATA_W = 7;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACC   = 2'd1,
    DONE  = 2'd2
  } sm_state_e;

  localparam logic [SM_DATA_W-1:0] SM_NEG_ZERO = 7'b1000000;
  localparam logic [SM_DATA_W-1:0] SM_POS_MAX  = 7'b0111111;
  localparam logic [SM_DATA_W-1:0] SM_NEG_MAX  = 7'b1111111;

endpackage

// File: rtl/signed_mag_compare.sv
// Orders two sign-magnitude values; +0 and -0 compare equal.
module signed_mag_compare #(
  parameter int DATA_W = 7
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              aLTb,
  output logic              aGTb
);

  logic              neg_a, neg_b;
  logic [DATA_W-2:0] mag_a, mag_b;

  assign mag_a = a[DATA_W-2:0];
  assign mag_b = b[DATA_W-2:0];
  // A zero magnitude is never negative, which folds -0 onto +0.
  assign neg_a = a[DATA_W-1] & (|mag_a);
  assign neg_b = b[DATA_W-1] & (|mag_b);

  always_comb begin
    aLTb = 1'b0;
    aGTb = 1'b0;
    if (neg_a != neg_b) begin
      aLTb = neg_a;
      aGTb = neg_b;
    end else if (neg_a) begin
      aLTb = (mag_a > mag_b);
      aGTb = (mag_a < mag_b);
    end else begin
      aLTb = (mag_a < mag_b);
      aGTb = (mag_a > mag_b);
    end
  end

endmodule

// File: rtl/sm_minmax_tracker.sv
// Tracks running min/max and sample count over a frame of sign-magnitude
// samples; presents them on a valid/ready output at frame end.
module sm_minmax_tracker
  import sm_pkg::*;
#(
  parameter int DATA_W = SM_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [DATA_W-1:0] out_max,
  output logic [CNT_W-1:0]  out_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  sm_state_e         state_q, state_d;
  logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              min_lt, max_gt;
  logic              min_gt_unused, max_lt_unused;

  signed_mag_compare #(.DATA_W(DATA_W)) cmp_min (
    .a    (in_data),
    .b    (min_q),
    .aLTb (min_lt),
    .aGTb (min_gt_unused)
  );

  signed_mag_compare #(.DATA_W(DATA_W)) cmp_max (
    .a    (in_data),
    .b    (max_q),
    .aLTb (max_lt_unused),
    .aGTb (max_gt)
  );

  assign in_ready  = (state_q == EMPTY) || (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid && in_ready;
  assign out_min   = min_q;
  assign out_max   = max_q;
  assign out_count = cnt_q;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          min_d   = in_data;
          max_d   = in_data;
          cnt_d   = CNT_ONE;
          state_d = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // Strict compares keep the stored encoding on ties.
          if (min_lt) min_d = in_data;
          if (max_gt) max_d = in_data;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_ONE;
          if (in_last) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sm_minmax_tracker.sv
// Directed plus randomized bench for sm_minmax_tracker against a frame-level model.
module tb_sm_minmax_tracker;
  import sm_pkg::*;

  localparam int DW = 7;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_min, out_max;
  logic [CW-1:0] out_count;

  int total = 0;
  int bad = 0;
  logic [DW-1:0] frame[$];

  sm_minmax_tracker #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  function automatic int smv(logic [DW-1:0] x);
    return x[DW-1] ? -int'(x[DW-2:0]) : int'(x[DW-2:0]);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(logic [DW-1:0] d, logic last);
    @(negedge clk);
    chk("in_ready_before_send", 32'(in_ready), 32'd1);
    chk("out_valid_during_frame", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    frame.push_back(d);
  endtask

  // Call right after the last sample's accept; holds out_ready low for h cycles.
  task automatic finish_frame(int h);
    logic [DW-1:0] emin, emax;
    int ecnt, n;
    emin = frame[0];
    emax = frame[0];
    foreach (frame[i]) begin
      if (smv(frame[i]) < smv(emin)) emin = frame[i];
      if (smv(frame[i]) > smv(emax)) emax = frame[i];
    end
    ecnt = (frame.size() > 255) ? 255 : frame.size();
    n = (h == 0) ? 1 : h;
    out_ready = (h == 0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("out_valid_high", 32'(out_valid), 32'd1);
      chk("in_ready_low_done", 32'(in_ready), 32'd0);
      chk("out_min", 32'(out_min), 32'(emin));
      chk("out_max", 32'(out_max), 32'(emax));
      chk("out_count", 32'(out_count), 32'(ecnt));
      if (k == n - 1) out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_dropped", 32'(out_valid), 32'd0);
    chk("in_ready_after_handoff", 32'(in_ready), 32'd1);
    chk("count_persists", 32'(out_count), 32'(ecnt));
    frame.delete();
  endtask

  initial begin
    int len;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_min", 32'(out_min), 32'd0);
    chk("rst_out_max", 32'(out_max), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    #10 rst_n = 1'b1;

    send(7'b0000101, 1'b0);
    send(7'b1000011, 1'b0);
    send(7'b0010100, 1'b0);
    send(7'b1010001, 1'b1);
    finish_frame(0);

    send(7'b0001001, 1'b1);
    finish_frame(0);

    send(7'b0000001, 1'b0);
    send(7'b0000010, 1'b1);
    finish_frame(3);

    send(SM_NEG_ZERO, 1'b0);
    send(7'b0000000, 1'b1);
    chk("neg_zero_retained_min", 32'(out_min), 32'(SM_NEG_ZERO));
    finish_frame(0);

    send(SM_POS_MAX, 1'b0);
    send(SM_NEG_MAX, 1'b1);
    finish_frame(1);

    send(7'b0000100, 1'b0);
    send(7'b1000100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    frame.delete();
    send(7'b0000011, 1'b1);
    finish_frame(0);

    for (int i = 0; i < 300; i++) send(7'($urandom), i == 299);
    finish_frame(2);

    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) send(7'($urandom), i == len - 1);
      finish_frame($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
